// File: rtl/amber128_dmem_responder_if.sv
// Load/store request channel and response channel between the execute stage
// and the 128-bit data-memory responder.
interface amber128_dmem_responder_if;
    logic         req_valid_i;
    logic         req_ready_o;
    logic         req_we_i;
    logic [63:0]  req_addr_i;
    logic [127:0] req_wdata_i;
    logic         resp_valid_o;
    logic         resp_ready_i;
    logic [127:0] resp_rdata_o;
    logic         resp_fault_o;
    logic [2:0]   resp_cause_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o, resp_cause_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o, resp_cause_o
    );
endinterface

// File: rtl/amber128_dmem_responder.sv
// 128-bit data-memory responder: one outstanding load/store, alignment/range
// fault check, fixed RD_LATENCY response. Optional counters: AMBER128_DMEM_STATS_EN.
module amber128_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic clk,
    input  logic rst,
    amber128_dmem_responder_if.slave bus
`ifdef AMBER128_DMEM_STATS_EN
    ,
    output logic [31:0] stat_loads_o,
    output logic [31:0] stat_stores_o,
    output logic [31:0] stat_faults_o
`endif
);
    localparam int unsigned IDX_W           = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  TRAP_NONE       = 3'd0;
    localparam logic [2:0]  TRAP_DATA_FAULT = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic               req_ready_r;
    logic               resp_valid_r;
    logic [127:0]       resp_rdata_r;
    logic               resp_fault_r;
    logic [2:0]         resp_cause_r;
    logic [1:0]         cnt_r;
    logic               we_r;
    logic               fault_r;
    logic [IDX_W-1:0]   index_r;
    logic [127:0]       mem_r [DEPTH_WORDS];

    logic [63:0]        off_s;
    logic               accept_s;
    logic               fault_s;
    logic [IDX_W-1:0]   index_s;
    logic               sel_we_s;
    logic               sel_fault_s;
    logic [IDX_W-1:0]   sel_index_s;
    logic [127:0]       rsp_rdata_s;

    // Address decode of the request on the bus; BASE_ADDR is 16-byte aligned so off[3:0] equals addr[3:0].
    always_comb begin
        off_s    = bus.req_addr_i - BASE_ADDR;
        accept_s = bus.req_valid_i && req_ready_r;
        fault_s  = (off_s[3:0] != 4'd0) || (bus.req_addr_i < BASE_ADDR) ||
                   ({4'd0, off_s[63:4]} >= 64'(DEPTH_WORDS));
        index_s  = off_s[IDX_W+3:4];
    end

    // Response payload for the edge entering RESP: live request when RD_LATENCY is 1, captured one otherwise.
    always_comb begin
        if (state_r == ST_IDLE) begin
            sel_we_s    = bus.req_we_i;
            sel_fault_s = fault_s;
            sel_index_s = index_s;
        end else begin
            sel_we_s    = we_r;
            sel_fault_s = fault_r;
            sel_index_s = index_r;
        end
        if (!sel_we_s && !sel_fault_s) begin
            rsp_rdata_s = mem_r[sel_index_s];
        end else begin
            rsp_rdata_s = 128'd0;
        end
    end

    // Array write port; contents survive reset, faulting stores never reach it.
    always_ff @(posedge clk) begin
        if (!rst && accept_s && bus.req_we_i && !fault_s) begin
            mem_r[index_s] <= bus.req_wdata_i;
        end
    end

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 128'd0;
            resp_fault_r <= 1'b0;
            resp_cause_r <= TRAP_NONE;
            cnt_r        <= 2'd0;
            we_r         <= 1'b0;
            fault_r      <= 1'b0;
            index_r      <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    req_ready_r <= 1'b1;
                    if (accept_s) begin
                        req_ready_r <= 1'b0;
                        we_r        <= bus.req_we_i;
                        fault_r     <= fault_s;
                        index_r     <= index_s;
                        cnt_r       <= 2'(RD_LATENCY - 1);
                        if (RD_LATENCY > 1) begin
                            state_r <= ST_WAIT;
                        end else begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= rsp_rdata_s;
                            resp_fault_r <= sel_fault_s;
                            resp_cause_r <= sel_fault_s ? TRAP_DATA_FAULT : TRAP_NONE;
                        end
                    end
                end
                ST_WAIT: begin
                    // The edge that takes the counter to zero is the one that presents the response.
                    cnt_r <= cnt_r - 2'd1;
                    if (cnt_r == 2'd1) begin
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_rdata_r <= rsp_rdata_s;
                        resp_fault_r <= sel_fault_s;
                        resp_cause_r <= sel_fault_s ? TRAP_DATA_FAULT : TRAP_NONE;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready_i) begin
                        state_r      <= ST_IDLE;
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b0;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready_o  = req_ready_r;
    assign bus.resp_valid_o = resp_valid_r;
    assign bus.resp_rdata_o = resp_rdata_r;
    assign bus.resp_fault_o = resp_fault_r;
    assign bus.resp_cause_o = resp_cause_r;

`ifdef AMBER128_DMEM_STATS_EN
    logic [31:0] stat_loads_r;
    logic [31:0] stat_stores_r;
    logic [31:0] stat_faults_r;

    // Per-class request counters, bumped on the acceptance edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_loads_r  <= 32'd0;
            stat_stores_r <= 32'd0;
            stat_faults_r <= 32'd0;
        end else if (accept_s) begin
            if (fault_s) begin
                stat_faults_r <= stat_faults_r + 32'd1;
            end else if (bus.req_we_i) begin
                stat_stores_r <= stat_stores_r + 32'd1;
            end else begin
                stat_loads_r  <= stat_loads_r + 32'd1;
            end
        end
    end

    assign stat_loads_o  = stat_loads_r;
    assign stat_stores_o = stat_stores_r;
    assign stat_faults_o = stat_faults_r;
`endif
endmodule

// File: tb/tb_amber128_dmem_responder.sv
// Scoreboard bench for amber128_dmem_responder: directed cases plus random
// traffic against an address-level memory model.
`timescale 1ns/1ps
module tb_amber128_dmem_responder;
    localparam int unsigned DEPTH = 64;
    localparam logic [63:0] BASE  = 64'h1000;
    localparam int unsigned LAT   = 3;

    typedef struct {
        logic [127:0] rdata;
        bit           fault;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t cur;
    logic [127:0] model_mem [int];
    int   stall_left = 0;
    bit   rst_seen = 1'b0;
    bit   hs_seen = 1'b0;
    bit   showing = 1'b0;
    int   m_loads = 0;
    int   m_stores = 0;
    int   m_faults = 0;

    amber128_dmem_responder_if bus ();

`ifdef AMBER128_DMEM_STATS_EN
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_faults;
`endif

    amber128_dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR(BASE),
        .RD_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef AMBER128_DMEM_STATS_EN
        ,
        .stat_loads_o(stat_loads),
        .stat_stores_o(stat_stores),
        .stat_faults_o(stat_faults)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
        hs_seen  <= (bus.resp_valid_o === 1'b1) && (bus.resp_ready_i === 1'b1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit model_fault(input logic [63:0] a);
        return (a % 64'd16 != 64'd0) || (a < BASE) || (a - BASE >= 64'(DEPTH) * 64'd16);
    endfunction

    // Monitor: pops the scoreboard on each new response and owns resp_ready_i.
    initial begin : monitor
        bus.resp_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                check("rst_req_ready", 128'(bus.req_ready_o), 128'd0);
                check("rst_resp_valid", 128'(bus.resp_valid_o), 128'd0);
                check("rst_rdata", bus.resp_rdata_o, 128'd0);
                check("rst_fault", 128'(bus.resp_fault_o), 128'd0);
                check("rst_cause", 128'(bus.resp_cause_o), 128'd0);
                showing = 1'b0;
            end else if (hs_seen) begin
                check("post_hs_valid", 128'(bus.resp_valid_o), 128'd0);
                check("post_hs_req_ready", 128'(bus.req_ready_o), 128'd1);
                check("post_hs_rdata_hold", bus.resp_rdata_o, cur.rdata);
                check("post_hs_fault_hold", 128'(bus.resp_fault_o), 128'(cur.fault));
                showing = 1'b0;
            end else if (bus.resp_valid_o === 1'b1) begin
                check("busy_req_ready", 128'(bus.req_ready_o), 128'd0);
                if (!showing) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected no response", cyc);
                    end else begin
                        cur = exp_q.pop_front();
                        showing = 1'b1;
                        check("latency", 128'(cyc - cur.acc), 128'(LAT));
                        check("rdata", bus.resp_rdata_o, cur.rdata);
                        check("fault", 128'(bus.resp_fault_o), 128'(cur.fault));
                        check("cause", 128'(bus.resp_cause_o), cur.fault ? 128'd2 : 128'd0);
                    end
                end else begin
                    check("stall_rdata", bus.resp_rdata_o, cur.rdata);
                    check("stall_fault", 128'(bus.resp_fault_o), 128'(cur.fault));
                    check("stall_cause", 128'(bus.resp_cause_o), cur.fault ? 128'd2 : 128'd0);
                end
            end
            if (stall_left > 0 && bus.resp_valid_o === 1'b1) begin
                bus.resp_ready_i = 1'b0;
                stall_left--;
            end else begin
                bus.resp_ready_i = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic issue(input bit we, input logic [63:0] addr, input logic [127:0] wd, input bit tracked);
        int   guard;
        int   idx;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (bus.req_ready_o !== 1'b1) begin
            if (guard == 400) begin
                checks++;
                errors++;
                $display("FAIL req_ready_timeout: ready=%b after %0d cycles, expected 1", bus.req_ready_o, guard);
                return;
            end
            guard++;
            @(negedge clk);
        end
        e.fault = model_fault(addr);
        e.acc   = cyc;
        e.rdata = 128'd0;
        if (e.fault) begin
            m_faults++;
        end else begin
            idx = int'((addr - BASE) >> 4);
            if (we) begin
                model_mem[idx] = wd;
                m_stores++;
            end else begin
                e.rdata = model_mem[idx];
                m_loads++;
            end
        end
        if (tracked) exp_q.push_back(e);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = 64'hFFFF_FFFF_FFFF_FFF7;
        bus.req_wdata_i = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || showing) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        m_loads  = 0;
        m_stores = 0;
        m_faults = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_stats(input string tag);
`ifdef AMBER128_DMEM_STATS_EN
        check({tag, "_stat_loads"}, 128'(stat_loads), 128'(m_loads));
        check({tag, "_stat_stores"}, 128'(stat_stores), 128'(m_stores));
        check({tag, "_stat_faults"}, 128'(stat_faults), 128'(m_faults));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int               kind;
        int unsigned      widx;
        logic [63:0]      a;
        bit               w;
        logic [127:0]     d;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = 64'd0;
        bus.req_wdata_i = 128'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_stats("after_reset");

        issue(1'b1, BASE + 64'h20, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b1);
        issue(1'b0, BASE + 64'h20, 128'd0, 1'b1);
        issue(1'b1, BASE + 64'h28, 128'hDEAD_BEEF, 1'b1);
        issue(1'b0, BASE + 64'h20, 128'd0, 1'b1);
        issue(1'b0, BASE + 64'(DEPTH) * 64'd16, 128'd0, 1'b1);
        issue(1'b0, 64'h0FF0, 128'd0, 1'b1);
        issue(1'b0, BASE + 64'(DEPTH - 1) * 64'd16, 128'd0, 1'b1);
        wait_drain();
        stall_left = 5;
        issue(1'b0, BASE + 64'h20, 128'd0, 1'b1);
        wait_drain();

        // Store accepted, then reset while it is still waiting: no response, data committed.
        issue(1'b1, BASE + 64'h30, 128'hA5, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        m_loads  = 0;
        m_stores = 0;
        m_faults = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(1'b0, BASE + 64'h30, 128'd0, 1'b1);
        wait_drain();

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            widx = $urandom_range(0, DEPTH - 1);
            a    = BASE + 64'(widx) * 64'd16;
            w    = ($urandom_range(0, 1) == 1);
            d    = {$urandom, $urandom, $urandom, $urandom};
            if (kind == 0) begin
                a = a + 64'($urandom_range(1, 15));
            end else if (kind == 1) begin
                a = BASE - 64'($urandom_range(1, 64)) * 64'd16;
            end else if (kind == 2) begin
                a = BASE + 64'(DEPTH) * 64'd16 + 64'($urandom_range(0, 1000)) * 64'd16;
            end else if (!w && !model_mem.exists(int'(widx))) begin
                w = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) stall_left = $urandom_range(1, 4);
            issue(w, a, d, 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        wait_drain();
        check_stats("after_traffic");
        pulse_reset();
        @(negedge clk);
        check_stats("after_final_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
